// File: rtl/aes_pkg.sv
// AES shared helpers: GF(2^8) arithmetic, MixColumns coefficients, iterator FSM states.
// Purely combinational functions; no latency, no backpressure.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_e;

    // Circulant first rows, MSB byte is the diagonal coefficient.
    localparam logic [31:0] MC_FWD_COEF = 32'h02_03_01_01;
    localparam logic [31:0] MC_INV_COEF = 32'h0e_0b_0d_09;

    localparam logic [7:0] AES_POLY_LOW = 8'h1b;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY_LOW : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ t;
            end
            t = xtime(t);
        end
        return p;
    endfunction

    // Coefficient at circulant distance d (0..3) from the diagonal.
    function automatic logic [7:0] mc_coef(input logic inv, input logic [1:0] d);
        logic [31:0] row;
        row = inv ? MC_INV_COEF : MC_FWD_COEF;
        return row[{~d, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mix_column_unit.sv
// One 32-bit AES column through MixColumns (inv_i=0) or InvMixColumns (inv_i=1).
// Combinational, zero latency, no backpressure.
module mix_column_unit
    import aes_pkg::*;
(
    input  logic [31:0] col_i,
    input  logic        inv_i,
    output logic [31:0] col_o
);

    logic [7:0] a [4];
    logic [7:0] b [4];

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            a[j] = col_i[8*(3-j) +: 8];
        end
    end

    // Row r output = XOR over j of coef[(j - r) mod 4] * a[j]; row 0 is the MSB byte.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            b[r] = 8'h00;
            for (int j = 0; j < 4; j++) begin
                b[r] = b[r] ^ gf_mul(mc_coef(inv_i, 2'(j - r)), a[j]);
            end
        end
    end

    assign col_o = {b[0], b[1], b[2], b[3]};

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES (Inv)MixColumns: COLS_PER_CYCLE columns per clock, result after 4/COLS_PER_CYCLE cycles;
// result held in DONE until out_ready. Optional bypass port when AES_MIXCOL_BYPASS_EN is defined.
module mix_columns_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] input_s,
    input  logic         inv,
`ifdef AES_MIXCOL_BYPASS_EN
    input  logic         bypass,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] output_s
);

    localparam int          STEPS    = 4 / COLS_PER_CYCLE;
    localparam logic [1:0]  LAST_COL = 2'(STEPS - 1);

    mc_state_e    state_q;
    logic [1:0]   col_q;
    logic [127:0] data_q;
    logic [127:0] data_d;
    logic         inv_q;
    logic         byp_q;
    logic         out_valid_q;
    logic         byp_in;
    logic         accept;

`ifdef AES_MIXCOL_BYPASS_EN
    assign byp_in = bypass;
`else
    assign byp_in = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign output_s  = data_q;

    logic [1:0]  col_idx  [COLS_PER_CYCLE];
    logic [31:0] unit_in  [COLS_PER_CYCLE];
    logic [31:0] unit_out [COLS_PER_CYCLE];

    // Column c lives at bits [127-32c -: 32], i.e. base offset 32*(3-c) = {~c, 5'b0}.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_unit
        assign col_idx[g] = 2'(int'(col_q) * COLS_PER_CYCLE + g);
        assign unit_in[g] = data_q[{~col_idx[g], 5'b00000} +: 32];

        mix_column_unit u_col (
            .col_i (unit_in[g]),
            .inv_i (inv_q),
            .col_o (unit_out[g])
        );
    end

    always_comb begin
        data_d = data_q;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            data_d[{~col_idx[g], 5'b00000} +: 32] = byp_q ? unit_in[g] : unit_out[g];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= 2'd0;
            data_q      <= '0;
            inv_q       <= 1'b0;
            byp_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        data_q  <= input_s;
                        inv_q   <= inv;
                        byp_q   <= byp_in;
                        col_q   <= 2'd0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    data_q <= data_d;
                    if (col_q == LAST_COL) begin
                        col_q       <= 2'd0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        col_q <= 2'(col_q + 2'd1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (in_valid) begin
                            data_q  <= input_s;
                            inv_q   <= inv;
                            byp_q   <= byp_in;
                            col_q   <= 2'd0;
                            state_q <= BUSY;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    col_q       <= 2'd0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Self-checking bench for mix_columns_iter at COLS_PER_CYCLE = 1, 2, 4 against a GF(2^8) matrix model.
module tb_mix_columns_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid_a  [3];
    logic         in_ready_a  [3];
    logic [127:0] in_s_a      [3];
    logic         inv_a       [3];
    logic         out_valid_a [3];
    logic         out_ready_a [3];
    logic [127:0] out_s_a     [3];
`ifdef AES_MIXCOL_BYPASS_EN
    logic         byp_a       [3];
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        mix_columns_iter #(.COLS_PER_CYCLE(1 << k)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_a[k]),
            .in_ready  (in_ready_a[k]),
            .input_s   (in_s_a[k]),
            .inv       (inv_a[k]),
`ifdef AES_MIXCOL_BYPASS_EN
            .bypass    (byp_a[k]),
`endif
            .out_valid (out_valid_a[k]),
            .out_ready (out_ready_a[k]),
            .output_s  (out_s_a[k])
        );
    end

    // Reference: carry-less product reduced modulo x^8+x^4+x^3+x+1, then the 4x4 circulant matrix.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int bt = 14; bt >= 8; bt--)
            if (p[bt]) p = p ^ 15'(16'h011b << (bt - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] model_mix(input logic [127:0] s, input logic iv);
        int fc [4];
        int ic [4];
        logic [127:0] r;
        logic [7:0] a [4];
        logic [7:0] acc;
        fc = '{2, 3, 1, 1};
        ic = '{14, 11, 13, 9};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(8'(iv ? ic[(j - row + 4) % 4] : fc[(j - row + 4) % 4]), a[j]);
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one state, scramble inputs after acceptance, measure latency, then consume.
    task automatic run_txn(input int k, input logic [127:0] din, input logic iv, input logic byp,
                           output logic [127:0] dout, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (in_ready_a[k] !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        in_valid_a[k] = 1'b1;
        in_s_a[k]     = din;
        inv_a[k]      = iv;
`ifdef AES_MIXCOL_BYPASS_EN
        byp_a[k]      = byp;
`endif
        @(negedge clk);
        in_valid_a[k] = 1'b0;
        in_s_a[k]     = rnd128();
        inv_a[k]      = ~iv;
`ifdef AES_MIXCOL_BYPASS_EN
        byp_a[k]      = ~byp;
`endif
        lat = 0;
        while (out_valid_a[k] !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        dout = out_s_a[k];
        out_ready_a[k] = 1'b1;
        @(negedge clk);
        out_ready_a[k] = 1'b0;
    endtask

    task automatic check_txn(input string tag, input int k, input logic [127:0] din, input logic iv,
                             input logic byp, input logic [127:0] exp);
        logic [127:0] dout;
        int lat;
        run_txn(k, din, iv, byp, dout, lat);
        chk($sformatf("%s_data_k%0d", tag, k), dout, exp);
        chk($sformatf("%s_lat_k%0d", tag, k), 128'(lat), 128'(4 >> k));
    endtask

    initial begin
        logic [127:0] a_vec, b_vec, hold, dres;
        logic         iv, ib;
        int           lat;

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid_a[k]  = 1'b0;
            in_s_a[k]      = '0;
            inv_a[k]       = 1'b0;
            out_ready_a[k] = 1'b0;
`ifdef AES_MIXCOL_BYPASS_EN
            byp_a[k]       = 1'b0;
`endif
        end
        #12;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_out_valid_k%0d", k), 128'(out_valid_a[k]), 128'(0));
            chk($sformatf("rst_in_ready_k%0d", k), 128'(in_ready_a[k]), 128'(1));
            chk($sformatf("rst_output_k%0d", k), out_s_a[k], 128'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_rst_no_txn", 128'(out_valid_a[0]), 128'(0));

        // Known inverse vector at every width.
        for (int k = 0; k < 3; k++)
            check_txn("inv_known", k, 128'h75ec0993200b633353c0cf7cbb25d0dc, 1'b1, 1'b0,
                      128'hacc1d6b8efb55a7b1323cfdf457311b5);

        // Forward vector, then inverse of its output returns the original.
        for (int k = 0; k < 3; k++) begin
            check_txn("fwd_known", k, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 1'b0,
                      128'h046681e5e0cb199a48f8d37a2806264c);
            check_txn("fwd_roundtrip", k, 128'h046681e5e0cb199a48f8d37a2806264c, 1'b1, 1'b0,
                      128'hd4bf5d30e0b452aeb84111f11e2798e5);
        end

        for (int k = 0; k < 3; k++)
            for (int n = 0; n < 6; n++) begin
                a_vec = rnd128();
                iv    = 1'($urandom_range(0, 1));
                check_txn("random", k, a_vec, iv, 1'b0, model_mix(a_vec, iv));
            end

        // Back-to-back with out_ready held high on the single-column instance.
        b_vec = rnd128();
        ib    = 1'($urandom_range(0, 1));
        @(negedge clk);
        out_ready_a[0] = 1'b1;
        in_valid_a[0]  = 1'b1;
        in_s_a[0]      = 128'h584dcaf11b4b5aacdbe7caa81b6bb0e5;
        inv_a[0]       = 1'b1;
        @(negedge clk);
        in_s_a[0] = b_vec;
        inv_a[0]  = ib;
        chk("b2b_busy_in_ready", 128'(in_ready_a[0]), 128'(0));
        lat = 0;
        while (out_valid_a[0] !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_first_data", out_s_a[0], 128'h49db873b453953897f02d2f177de961a);
        chk("b2b_first_lat", 128'(lat), 128'(4));
        chk("b2b_done_in_ready", 128'(in_ready_a[0]), 128'(1));
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        in_s_a[0]     = rnd128();
        chk("b2b_second_accepted", 128'(out_valid_a[0]), 128'(0));
        lat = 0;
        while (out_valid_a[0] !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_second_data", out_s_a[0], model_mix(b_vec, ib));
        chk("b2b_second_lat", 128'(lat), 128'(4));
        @(negedge clk);
        out_ready_a[0] = 1'b0;

        // Backpressure: result held for 5 cycles while a new offer waits.
        a_vec = rnd128();
        @(negedge clk);
        in_valid_a[0] = 1'b1;
        in_s_a[0]     = a_vec;
        inv_a[0]      = 1'b0;
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        lat = 0;
        while (out_valid_a[0] !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        hold = out_s_a[0];
        chk("bp_result", hold, model_mix(a_vec, 1'b0));
        in_valid_a[0] = 1'b1;
        in_s_a[0]     = rnd128();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_out_valid_c%0d", i), 128'(out_valid_a[0]), 128'(1));
            chk($sformatf("bp_output_c%0d", i), out_s_a[0], hold);
            chk($sformatf("bp_in_ready_c%0d", i), 128'(in_ready_a[0]), 128'(0));
        end
        in_valid_a[0]  = 1'b0;
        out_ready_a[0] = 1'b1;
        @(negedge clk);
        out_ready_a[0] = 1'b0;
        chk("bp_release_idle_valid", 128'(out_valid_a[0]), 128'(0));
        chk("bp_release_in_ready", 128'(in_ready_a[0]), 128'(1));
        repeat (6) @(negedge clk);
        chk("bp_offer_not_taken", 128'(out_valid_a[0]), 128'(0));

        // Reset after two columns have been written.
        @(negedge clk);
        in_valid_a[0] = 1'b1;
        in_s_a[0]     = rnd128();
        inv_a[0]      = 1'b1;
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(out_valid_a[0]), 128'(0));
        chk("midrst_in_ready", 128'(in_ready_a[0]), 128'(1));
        chk("midrst_output", out_s_a[0], 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst_never_presented", 128'(out_valid_a[0]), 128'(0));
        a_vec = rnd128();
        check_txn("after_rst", 0, a_vec, 1'b0, 1'b0, model_mix(a_vec, 1'b0));
        run_txn(0, 128'h75ec0993200b633353c0cf7cbb25d0dc, 1'b1, 1'b0, dres, lat);
        chk("after_rst_known", dres, 128'hacc1d6b8efb55a7b1323cfdf457311b5);

`ifdef AES_MIXCOL_BYPASS_EN
        for (int k = 0; k < 3; k++)
            check_txn("bypass", k, 128'h046681e5e0cb199a48f8d37a2806264c, 1'b0, 1'b1,
                      128'h046681e5e0cb199a48f8d37a2806264c);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mix_columns_iter.md
MIX_COLUMNS_ITER -- requirements
Module: mix_columns_iter

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1, columns transformed per clock; legal values 1, 2, 4.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, input state offered.
REQ-005 SHALL have port in_ready, output, 1, block can accept a state.
REQ-006 SHALL have port input_s, input, 128, AES state; column c = bits [127-32c -: 32]; row 0 is the MSB byte of each column.
REQ-007 SHALL have port inv, input, 1, 0 = MixColumns, 1 = InvMixColumns.
REQ-008 SHALL have port out_valid, output, 1, output_s holds a finished result.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-010 SHALL have port output_s, output, 128, transformed state, same byte layout as input_s.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-012 SHALL accept a state when in_valid and in_ready are both high at a clock edge, capturing input_s and inv into internal registers and entering BUSY.
REQ-013 SHALL drive in_ready high in IDLE, and in DONE only when out_ready is high; low in BUSY.
REQ-014 SHALL in BUSY transform COLS_PER_CYCLE columns per edge, starting with column 0 and proceeding in ascending order, using a column counter that counts from 0 to 4/COLS_PER_CYCLE-1.
REQ-015 SHALL enter DONE with out_valid high on the edge that writes the last column, giving out_valid exactly 4/COLS_PER_CYCLE cycles after acceptance (4, 2, 1).
REQ-016 SHALL hold output_s and out_valid stable in DONE until out_ready is high.
REQ-017 SHALL, in DONE with out_ready high, return to IDLE, or go directly to BUSY when in_valid is also high (back-to-back with no bubble).
REQ-018 SHALL ignore changes to inv and input_s after acceptance; the mode is latched per state.
REQ-019 SHALL compute forward MixColumns with GF(2^8) coefficients {02,03,01,01} and inverse with {0e,0b,0d,09}, reduction polynomial 0x11b.
REQ-020 SHALL keep output_s equal to the internal result register at all times; its value is not defined as meaningful while out_valid is low.

Reset
REQ-021 SHALL, while rst_n is low, force state IDLE, column counter 0, out_valid 0, in_ready 1, output_s 0, latched inv 0.
REQ-022 SHALL abort any in-flight operation on reset; the partially processed state is discarded and never presented.
REQ-023 SHALL take no transaction on the first edge after rst_n deasserts unless in_valid is high on that edge.

Configuration
REQ-024 SHALL, when macro AES_MIXCOL_BYPASS_EN is defined, add input port bypass (1 bit, latched at acceptance); with bypass=1 the result equals input_s unchanged, with identical latency and handshake (final AES round).
REQ-025 SHALL, when AES_MIXCOL_BYPASS_EN is undefined, omit the bypass port and always transform.

Structure
REQ-026 SHALL take the xtime function, GF multiply helper, the forward/inverse coefficient constants and the FSM state enum from shared package aes_pkg.
REQ-027 SHALL instantiate COLS_PER_CYCLE copies of the sub-module mix_column_unit (32-bit combinational column transform with an inv select).

Verification
REQ-028 Bench SHALL check: inv=1, input 75ec0993200b633353c0cf7cbb25d0dc -> acc1d6b8efb55a7b1323cfdf457311b5, for each COLS_PER_CYCLE at latencies 4/2/1.
REQ-029 Bench SHALL check: inv=0, input d4bf5d30e0b452aeb84111f11e2798e5 -> 046681e5e0cb199a48f8d37a2806264c; then inv=1 on that output -> original.
REQ-030 Bench SHALL check back-to-back: with out_ready held high, 584dcaf11b4b5aacdbe7caa81b6bb0e5 (inv=1) immediately followed by a second state -> 49db873b453953897f02d2f177de961a, then the second result, with no idle cycle between them.
REQ-031 Bench SHALL check backpressure: out_ready low for 5 cycles -> output_s and out_valid stable, in_ready low, a new in_valid not accepted.
REQ-032 Bench SHALL check reset mid-BUSY (COLS_PER_CYCLE=1, after 2 columns) -> out_valid 0, in_ready 1, output_s 0; a following transaction yields the correct result.
REQ-033 Bench SHALL check, with AES_MIXCOL_BYPASS_EN defined and bypass=1, input 046681e5e0cb199a48f8d37a2806264c -> identical output at normal latency.
